// File: rtl/branch_pkg.sv
// Shared types for the branch predict unit: branch encodings, counter states and helpers.
package branch_pkg;

  typedef enum logic [2:0] {
    BrNone = 3'b000,
    BrEq   = 3'b001,
    BrNe   = 3'b010,
    BrLt   = 3'b011,
    BrGe   = 3'b100,
    BrLtu  = 3'b101,
    BrGeu  = 3'b110,
    BrJump = 3'b111
  } branch_type_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic is_conditional(input branch_type_e t);
    return (t != BrNone) && (t != BrJump);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing signals of the branch predict unit.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  import branch_pkg::*;

  logic [XLEN-1:0]  pc_f;
  logic             predict_taken_f;
  logic             ex_valid;
  logic [XLEN-1:0]  pc_e;
  branch_type_e     branch_type;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic             predicted_e;
  logic             branch_taken;
  logic             mispredict;
  logic             clear_stats;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output pc_f, ex_valid, pc_e, branch_type, rdata1, rdata2, predicted_e, clear_stats,
    input  predict_taken_f, branch_taken, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  pc_f, ex_valid, pc_e, branch_type, rdata1, rdata2, predicted_e, clear_stats,
    output predict_taken_f, branch_taken, mispredict, branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition resolver for any operand width.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  branch_type_e    branch_type,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic            branch_taken
);

  always_comb begin
    branch_taken = 1'b0;
    case (branch_type)
      BrNone: branch_taken = 1'b0;
      BrEq:   branch_taken = (rdata1 == rdata2);
      BrNe:   branch_taken = (rdata1 != rdata2);
      BrLt:   branch_taken = ($signed(rdata1) < $signed(rdata2));
      BrGe:   branch_taken = ($signed(rdata1) >= $signed(rdata2));
      BrLtu:  branch_taken = (rdata1 < rdata2);
      BrGeu:  branch_taken = (rdata1 >= rdata2);
      BrJump: branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, 2-bit saturating BHT predictor and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32,
  parameter logic [1:0]  INIT_STATE  = WNT
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             taken;
  logic             bht_we;
  logic             count_br;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispredict_count_q;
  logic             unused_pc;

  assign idx_f     = bus.pc_f[IDX_W+1:2];
  assign idx_e     = bus.pc_e[IDX_W+1:2];
  assign unused_pc = ^{bus.pc_f[XLEN-1:IDX_W+2], bus.pc_f[1:0],
                       bus.pc_e[XLEN-1:IDX_W+2], bus.pc_e[1:0]};

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .branch_type (bus.branch_type),
    .rdata1      (bus.rdata1),
    .rdata2      (bus.rdata2),
    .branch_taken(taken)
  );

  assign bht_we     = bus.ex_valid && is_conditional(bus.branch_type);
  assign count_br   = bus.ex_valid && (bus.branch_type != BrNone);
  assign mispredict = count_br && (taken != bus.predicted_e);

  // Per-entry counter transition for the entry being resolved in execute.
  always_comb begin
    bht_d = bht_q[idx_e];
    case (bht_q[idx_e])
      SNT: bht_d = taken ? WNT : SNT;
      WNT: bht_d = taken ? WT  : SNT;
      WT:  bht_d = taken ? ST  : WNT;
      ST:  bht_d = taken ? ST  : WT;
      default: bht_d = bht_q[idx_e];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= INIT_STATE;
      end
    end else if (bht_we) begin
      bht_q[idx_e] <= bht_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.clear_stats) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (count_br && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + CntOne;
      end
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + CntOne;
      end
    end
  end

  // Prediction reads the registered entry: a same-cycle update is seen one cycle later.
  assign bus.predict_taken_f  = bht_q[idx_f][1];
  assign bus.branch_taken     = taken;
  assign bus.mispredict       = mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (XLEN=32, 64 entries, 4-bit counters).
module tb_branch_predict_unit;
  import branch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(
    .XLEN       (XLEN),
    .BHT_ENTRIES(64),
    .CNT_W      (CNT_W),
    .INIT_STATE (2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input branch_type_e t,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    bus.ex_valid    = v;
    bus.pc_e        = pc;
    bus.branch_type = t;
    bus.rdata1      = a;
    bus.rdata2      = b;
    bus.predicted_e = pred;
    #1;
  endtask

  task automatic chk_counts(input string tag, input int br, input int mp);
    chk({tag, "_brcnt"}, 32'(bus.branch_count), 32'(br));
    chk({tag, "_mpcnt"}, 32'(bus.mispredict_count), 32'(mp));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.pc_f        = '0;
    bus.clear_stats = 1'b0;
    drive(1'b0, 32'h0, BrJump, 32'h0, 32'h0, 1'b0);
    // Combinational resolution is live while reset is held.
    chk("taken_in_reset", 32'(bus.branch_taken), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state across every index
    for (int i = 0; i < 64; i++) begin
      bus.pc_f = 32'(i) << 2;
      #1;
      chk("reset_pred", 32'(bus.predict_taken_f), 32'd0);
    end
    chk_counts("reset", 0, 0);

    // Comparator, no state change while ex_valid=0
    drive(1'b0, 32'h0, BrLt, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("blt_neg", 32'(bus.branch_taken), 32'd1);
    drive(1'b0, 32'h0, BrLtu, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("bltu_big", 32'(bus.branch_taken), 32'd0);
    drive(1'b0, 32'h0, BrGeu, 32'h5, 32'h5, 1'b0);
    chk("bgeu_eq", 32'(bus.branch_taken), 32'd1);
    drive(1'b0, 32'h0, BrGe, 32'h8000_0000, 32'h0, 1'b0);
    chk("bge_neg", 32'(bus.branch_taken), 32'd0);
    drive(1'b0, 32'h0, BrNe, 32'h5, 32'h5, 1'b0);
    chk("bne_eq", 32'(bus.branch_taken), 32'd0);
    drive(1'b0, 32'h0, BrEq, 32'h5, 32'h6, 1'b0);
    chk("beq_ne", 32'(bus.branch_taken), 32'd0);
    drive(1'b0, 32'h0, BrJump, 32'h0, 32'h0, 1'b0);
    chk("jump_gated_mp", 32'(bus.mispredict), 32'd0);
    tick();
    chk_counts("gated", 0, 0);

    // Four taken BEQ at 0x40 (entry 16): 01->10->11->11
    bus.pc_f = 32'h40;
    drive(1'b1, 32'h40, BrEq, 32'h7, 32'h7, 1'b0);
    chk("beq_t0_pred", 32'(bus.predict_taken_f), 32'd0);
    chk("beq_t0_mp", 32'(bus.mispredict), 32'd1);
    tick();
    chk("beq_t1_pred", 32'(bus.predict_taken_f), 32'd1);
    tick();
    chk("beq_t2_pred", 32'(bus.predict_taken_f), 32'd1);
    tick();
    chk("beq_t3_pred", 32'(bus.predict_taken_f), 32'd1);
    tick();
    // Two not-taken: 11->10->01
    drive(1'b1, 32'h40, BrEq, 32'h7, 32'h8, 1'b1);
    chk("beq_nt0_pred", 32'(bus.predict_taken_f), 32'd1);
    tick();
    chk("beq_nt1_pred", 32'(bus.predict_taken_f), 32'd1);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    chk("beq_nt2_pred", 32'(bus.predict_taken_f), 32'd0);
    chk_counts("beq", 6, 6);

    // Same-cycle read/write at 0x80: no bypass
    bus.pc_f = 32'h80;
    drive(1'b1, 32'h80, BrEq, 32'h3, 32'h3, 1'b1);
    chk("rw_same_pred", 32'(bus.predict_taken_f), 32'd0);
    chk("rw_same_mp", 32'(bus.mispredict), 32'd0);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    chk("rw_next_pred", 32'(bus.predict_taken_f), 32'd1);
    chk_counts("rw", 7, 6);

    // Jump with predicted_e=0 at 0x100 (entry 0)
    bus.pc_f = 32'h100;
    drive(1'b1, 32'h100, BrJump, 32'h0, 32'h0, 1'b0);
    chk("jump_mp", 32'(bus.mispredict), 32'd1);
    tick();
    chk_counts("jump", 8, 7);
    chk("jump_bht", 32'(bus.predict_taken_f), 32'd0);
    drive(1'b0, 32'h100, BrJump, 32'h0, 32'h0, 1'b0);
    chk("jump_inv_mp", 32'(bus.mispredict), 32'd0);
    tick();
    chk_counts("jump_inv", 8, 7);
    drive(1'b1, 32'h100, BrNone, 32'h0, 32'h0, 1'b1);
    chk("none_mp", 32'(bus.mispredict), 32'd0);
    chk("none_taken", 32'(bus.branch_taken), 32'd0);
    tick();
    chk_counts("none", 8, 7);

    // 20 mispredicting BNE at 0xC0 -> counters saturate at 15
    drive(1'b1, 32'hC0, BrNe, 32'h1, 32'h2, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk_counts("sat", 15, 15);
    bus.pc_f = 32'hC0;
    #1;
    chk("sat_pred", 32'(bus.predict_taken_f), 32'd1);

    // clear_stats with a branch: counters clear, BHT entry 0 still moves 01->10
    bus.pc_f        = 32'h200;
    bus.clear_stats = 1'b1;
    drive(1'b1, 32'h200, BrNe, 32'h1, 32'h2, 1'b0);
    tick();
    bus.clear_stats = 1'b0;
    #1;
    chk_counts("clear", 0, 0);
    chk("clear_bht", 32'(bus.predict_taken_f), 32'd1);
    tick();
    chk_counts("post_clear", 1, 1);

    // Asynchronous reset in mid-cycle with an update pending
    bus.pc_f = 32'hC0;
    drive(1'b1, 32'h40, BrEq, 32'h9, 32'h9, 1'b0);
    chk("pre_rst_pred", 32'(bus.predict_taken_f), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pred", 32'(bus.predict_taken_f), 32'd0);
    chk_counts("async_rst", 0, 0);
    chk("rst_taken", 32'(bus.branch_taken), 32'd1);
    chk("rst_mp", 32'(bus.mispredict), 32'd1);
    tick();
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    bus.pc_f = 32'h40;
    #1;
    chk("rst_discard_pred", 32'(bus.predict_taken_f), 32'd0);
    bus.pc_f = 32'h200;
    #1;
    chk("rst_entry0_pred", 32'(bus.predict_taken_f), 32'd0);
    chk_counts("rst_done", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's combinational branch comparator.
- Resolves the branch condition in execute for any XLEN.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters that gives a taken/not-taken prediction to fetch.
- Flags mispredictions to the hazard/flush logic and keeps saturating performance counters for branches and mispredicts.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of 2, ≥2.
- CNT_W, 32, width of each performance counter.
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_f  in  XLEN  fetch-stage PC, used for the prediction lookup.
- predict_taken_f  out  1  prediction for pc_f: the MSB of the indexed counter.
- ex_valid  in  1  execute stage holds a valid instruction (not a bubble or flush).
- pc_e  in  XLEN  execute-stage PC, used for the update index.
- branch_type  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 unconditional jump.
- rdata1  in  XLEN  rs1 operand.
- rdata2  in  XLEN  rs2 operand.
- predicted_e  in  1  prediction carried down the pipe with the instruction.
- branch_taken  out  1  resolved outcome (combinational).
- mispredict  out  1  ex_valid & (branch_type != 000) & (branch_taken != predicted_e).
- clear_stats  in  1  synchronous clear of the performance counters.
- branch_count  out  CNT_W  count of resolved branches and jumps.
- mispredict_count  out  CNT_W  count of mispredictions.

Behaviour:
- Comparison:
  - Signed compares use $signed on the full XLEN operands; unsigned compares are plain.
  - 000 gives 0, 111 gives 1.
  - Every encoding is decoded; branch_taken is 0 for anything unlisted.
- Index: IDX_W = $clog2(BHT_ENTRIES). idx_f = pc_f[IDX_W+1:2] and idx_e = pc_e[IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction:
  - Combinational read of bht[idx_f]: 1x means taken, 0x means not taken.
  - Zero-cycle latency from pc_f.
- BHT update:
  - On the clock edge when ex_valid and branch_type is in 001..110.
  - Taken: counter increments, saturating at 11. Not taken: counter decrements, saturating at 00.
  - Jumps (111) and type 000 never update the BHT.
  - ex_valid=0 blocks all updates and counting.
- Same-cycle read/write to the same index: the prediction returns the pre-update value, with no bypass. The new value is visible on the following cycle.
- mispredict:
  - Combinational, same cycle as resolution.
  - A jump with predicted_e=0 is a mispredict.
  - Type 000 never mispredicts.
- Performance counters:
  - branch_count increments when ex_valid and branch_type != 000.
  - mispredict_count increments when mispredict=1.
  - Both saturate at all-ones and never wrap.
  - clear_stats=1 zeroes both on the next edge. It takes priority over an increment in the same cycle; the counter reads 0, not 1.
- Reset:
  - All BHT entries go to INIT_STATE and both counters go to 0.
  - After reset, predict_taken_f = INIT_STATE[1], which is 0 by default.
  - Reset asserted mid-update discards the update.
  - Combinational outputs follow their inputs during reset.
- Simultaneous clear_stats, update and mispredict: the BHT still updates; only the counters clear.

Decomposition:
- Shared package (branch_pkg):
  - branch_type_e enum with the 3-bit encodings.
  - Counter-state constants: SNT=00, WNT=01, WT=10, ST=11.
  - is_conditional() helper function.
- Sub-module branch_cmp: purely combinational XLEN-parametrised comparator (branch_type, rdata1, rdata2 to branch_taken).
- The top level holds the BHT array, the update FSM per entry (the counter-state transitions) and the statistics counters.

Test Plan:
- Reset, then sweep pc_f across every index -> predict_taken_f=0 everywhere; counters read 0.
- XLEN=32, BLT, rdata1=32'hFFFF_FFFF, rdata2=1 -> taken=1. Same operands with BLTU -> taken=0. BGEU, rdata1=rdata2=5 -> taken=1.
- Four taken BEQ at pc_e=0x40 -> entry 16 steps 01→10→11→11 (saturates). predict_taken_f=1 for pc_f=0x40 from the cycle after the first update. Two not-taken updates -> 01, prediction 0.
- pc_f=pc_e=0x80, a taken update to a WNT entry -> predict_taken_f=0 that cycle and 1 the next cycle.
- Jump (111) with predicted_e=0 -> mispredict=1, both counters +1, BHT entry unchanged. Same jump with ex_valid=0 -> no mispredict, no count.
- CNT_W=4: 20 mispredicting branches -> both counters stick at 15. clear_stats together with a branch -> both counters 0 next cycle. Assert rst mid-stream -> BHT returns to INIT_STATE asynchronously.
